// File: rtl/fifo_if_pkg.sv
//-----------------------------------------------------------------------------
// fifo_if_pkg
//
// Purpose : Shared definitions for the write-side FIFO interface skid buffer.
//           Holds the occupancy encoding of the 2-entry skid buffer, the bit
//           positions of the debug status bus and a small helper that computes
//           the next occupancy from the push/pop handshakes.
//
// Contents:
//   occ_t           - skid-buffer occupancy: EMPTY(0), ONE(1), TWO(2)
//   DBG_*           - bit positions / field widths on the dbg bus
//   occ_step()      - next occupancy from current occupancy, push and pop
//-----------------------------------------------------------------------------
package fifo_if_pkg;

    // Occupancy of the skid buffer. Encoding 3 is never produced.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    // Debug bus layout
    localparam int DBG_MIN_WID       = 32;
    localparam int DBG_OLD_WEN_BIT   = 0;
    localparam int DBG_NEW_NFULL_BIT = 1;
    localparam int DBG_OLD_NFULL_BIT = 2;
    localparam int DBG_OVF_BIT       = 3;
    localparam int DBG_OCC_LSB       = 4;
    localparam int DBG_OCC_W         = 2;
    localparam int DBG_DROP_LSB      = 8;
    localparam int DBG_DROP_W        = 8;
    localparam int DBG_POP_LSB       = 16;
    localparam int DBG_POP_W         = 16;

    // Push-only grows by one, pop-only shrinks by one, both or neither keep
    // the occupancy. The caller guarantees that a push never reaches TWO and
    // a pop never reaches EMPTY, so no clamping is needed here.
    function automatic occ_t occ_step(input occ_t cur, input logic push,
                                      input logic pop);
        occ_t nxt;
        nxt = cur;
        case (cur)
            EMPTY: begin
                if (push) nxt = ONE;
            end
            ONE: begin
                if (push && !pop)      nxt = TWO;
                else if (!push && pop) nxt = EMPTY;
            end
            TWO: begin
                if (pop && !push) nxt = ONE;
            end
            default: nxt = EMPTY;
        endcase
        return nxt;
    endfunction

endpackage : fifo_if_pkg

// File: rtl/fifo_wrif_sk.sv
//-----------------------------------------------------------------------------
// fifo_wrif_sk
//
// Purpose : Two-entry skid buffer placed between an upstream writer and the
//           write port of a FIFO. The upstream side sees a registered ready
//           (new_nfull) so its timing is decoupled from the FIFO's not-full
//           signal; the FIFO side gets a write enable that is valid whenever
//           a word is stored and the FIFO can accept it. Words leave in strict
//           arrival order with one cycle of latency.
//
// Parameters:
//   DWID     - write data width (default 18)
//   DBG_WID  - debug bus width (default 32, must be at least 32)
//
// Ports:
//   clk            in   1        single clock
//   rst            in   1        synchronous active-high reset
//   new_wen        in   1        upstream write request
//   new_wdata      in   DWID     upstream write data
//   new_nfull      out  1        upstream ready (registered)
//   new_woverflow  out  1        sticky: write attempted while not ready
//   old_wen        out  1        FIFO write enable
//   old_wdata      out  DWID     FIFO write data (oldest stored word)
//   old_nfull      in   1        FIFO not-full
//   dbg            out  DBG_WID  debug status:
//                                [0] old_wen  [1] new_nfull  [2] old_nfull
//                                [3] new_woverflow  [5:4] occupancy
//                                [15:8]  dropped-write count (saturating)
//                                [31:16] pop count (wrapping)
//                                upper fields are zero unless the statistics
//                                option is built in.
//
// Build option:
//   FIFO_WRIF_STAT_EN - when defined, adds a 16-bit wrapping pop counter and
//                       an 8-bit saturating dropped-write counter on dbg.
//                       When undefined no counter logic exists and
//                       dbg[DBG_WID-1:8] is tied to zero.
//-----------------------------------------------------------------------------
module fifo_wrif_sk
    import fifo_if_pkg::*;
#(
    parameter int DWID    = 18,
    parameter int DBG_WID = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_wen,
    input  logic [DWID-1:0]    new_wdata,
    output logic               new_nfull,
    output logic               new_woverflow,
    output logic               old_wen,
    output logic [DWID-1:0]    old_wdata,
    input  logic               old_nfull,
    output logic [DBG_WID-1:0] dbg
);

    //-------------------------------------------------------------------------
    // State
    //-------------------------------------------------------------------------
    occ_t            r_occ;
    logic            r_nfull;
    logic            r_ovf;
    // r_word0 is always the oldest stored word, r_word1 the one behind it.
    logic [DWID-1:0] r_word0;
    logic [DWID-1:0] r_word1;

    //-------------------------------------------------------------------------
    // Handshakes
    //-------------------------------------------------------------------------
    logic w_old_wen;
    logic w_push;
    logic w_pop;
    logic w_drop;
    occ_t w_occ_next;

    assign w_old_wen  = (r_occ != EMPTY) & old_nfull;
    assign w_push     = new_wen & r_nfull;
    assign w_pop      = w_old_wen & old_nfull;
    // A write presented while not ready is lost; the storage never sees it.
    assign w_drop     = new_wen & ~r_nfull;
    assign w_occ_next = occ_step(r_occ, w_push, w_pop);

    //-------------------------------------------------------------------------
    // Control: occupancy, registered ready, sticky overflow
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ   <= EMPTY;
            r_nfull <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_occ   <= w_occ_next;
            // Ready is computed from the next occupancy so that a full buffer
            // is never offered to the writer, even on the cycle it fills.
            r_nfull <= (w_occ_next != TWO);
            r_ovf   <= r_ovf | w_drop;
        end
    end

    //-------------------------------------------------------------------------
    // Storage: data registers are not reset; the occupancy alone decides
    // which words are valid, so stale contents after reset are never emitted.
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        case (r_occ)
            EMPTY: begin
                if (w_push) r_word0 <= new_wdata;
            end
            ONE: begin
                // Simultaneous push/pop: the popped word leaves from slot 0
                // and the new word takes its place, keeping one word stored.
                if (w_push && w_pop) r_word0 <= new_wdata;
                else if (w_push)     r_word1 <= new_wdata;
            end
            TWO: begin
                // Ready is low while two words are held, so only a pop can
                // happen here; advance the younger word to the head.
                if (w_pop) r_word0 <= r_word1;
            end
            default: ;
        endcase
    end

    //-------------------------------------------------------------------------
    // Optional statistics counters
    //-------------------------------------------------------------------------
`ifdef FIFO_WRIF_STAT_EN
    logic [DBG_POP_W-1:0]  r_pop_cnt;
    logic [DBG_DROP_W-1:0] r_drop_cnt;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DBG_DROP_W-1:0] sat_inc(
        input logic [DBG_DROP_W-1:0] cnt, input logic en);
        logic [DBG_DROP_W-1:0] res;
        res = cnt;
        if (en && (cnt != {DBG_DROP_W{1'b1}})) res = cnt + 1'b1;
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pop_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_pop) r_pop_cnt <= r_pop_cnt + 1'b1;
            r_drop_cnt <= sat_inc(r_drop_cnt, w_drop);
        end
    end
`endif

    //-------------------------------------------------------------------------
    // Outputs
    //-------------------------------------------------------------------------
    assign new_nfull     = r_nfull;
    assign new_woverflow = r_ovf;
    assign old_wen       = w_old_wen;
    assign old_wdata     = r_word0;

    // DBG_WID below DBG_MIN_WID would truncate the counter fields.
    always_comb begin
        dbg                                  = '0;
        dbg[DBG_OLD_WEN_BIT]                 = w_old_wen;
        dbg[DBG_NEW_NFULL_BIT]               = r_nfull;
        dbg[DBG_OLD_NFULL_BIT]               = old_nfull;
        dbg[DBG_OVF_BIT]                     = r_ovf;
        dbg[DBG_OCC_LSB +: DBG_OCC_W]        = r_occ;
`ifdef FIFO_WRIF_STAT_EN
        dbg[DBG_DROP_LSB +: DBG_DROP_W]      = r_drop_cnt;
        dbg[DBG_POP_LSB +: DBG_POP_W]        = r_pop_cnt;
`endif
    end

endmodule : fifo_wrif_sk

// File: tb/tb_fifo_wrif_sk.sv
//-----------------------------------------------------------------------------
// tb_fifo_wrif_sk
//
// Directed bench for fifo_wrif_sk. Accepted writes push their data into an
// expected-word queue; a monitor on the falling edge pops and compares every
// word the DUT presents with old_wen high. Status outputs are checked
// directly against hand-derived values one time unit after the rising edge.
//-----------------------------------------------------------------------------
module tb_fifo_wrif_sk;

    localparam int DWID    = 18;
    localparam int DBG_WID = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               new_wen;
    logic [DWID-1:0]    new_wdata;
    logic               new_nfull;
    logic               new_woverflow;
    logic               old_wen;
    logic [DWID-1:0]    old_wdata;
    logic               old_nfull;
    logic [DBG_WID-1:0] dbg;

    int errors = 0;
    int checks = 0;
    logic [DWID-1:0] exp_q[$];

    fifo_wrif_sk #(.DWID(DWID), .DBG_WID(DBG_WID)) dut (
        .clk           (clk),
        .rst           (rst),
        .new_wen       (new_wen),
        .new_wdata     (new_wdata),
        .new_nfull     (new_nfull),
        .new_woverflow (new_woverflow),
        .old_wen       (old_wen),
        .old_wdata     (old_wdata),
        .old_nfull     (old_nfull),
        .dbg           (dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one write for one cycle; exp_acc is the hand-derived ready.
    task automatic write_word(input logic [DWID-1:0] data, input logic exp_acc);
        new_wen   = 1'b1;
        new_wdata = data;
        check("nfull_at_write", {31'd0, new_nfull}, {31'd0, exp_acc});
        if (exp_acc) exp_q.push_back(data);
        tick();
        new_wen = 1'b0;
    endtask

    // Scoreboard monitor: every word written to the FIFO must be the next
    // expected one.
    always @(negedge clk) begin
        logic [DWID-1:0] e;
        if (!rst && old_wen) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got 0x%0h, expected no write",
                         old_wdata);
            end else begin
                e = exp_q.pop_front();
                check("write_order", {14'd0, old_wdata}, {14'd0, e});
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        new_wen   = 1'b0;
        new_wdata = '0;
        old_nfull = 1'b1;

        // Reset state
        tick(); tick(); tick();
        check("rst_nfull",   {31'd0, new_nfull},     32'd0);
        check("rst_old_wen", {31'd0, old_wen},       32'd0);
        check("rst_ovf",     {31'd0, new_woverflow}, 32'd0);
        check("rst_dbg",     dbg,                    32'h4);

        // Ready rises on the first edge with reset low
        rst = 1'b0;
        tick();
        check("rel_nfull", {31'd0, new_nfull}, 32'd1);

        // Single word, latency one
        write_word(18'h000A1, 1'b1);
        check("lat_old_wen", {31'd0, old_wen},   32'd1);
        check("lat_wdata",   {14'd0, old_wdata}, 32'hA1);
        check("lat_nfull",   {31'd0, new_nfull}, 32'd1);
        tick();
        check("lat_drain", {31'd0, old_wen}, 32'd0);

        // Fill while FIFO is full
        old_nfull = 1'b0;
        write_word(18'h00011, 1'b1);
        write_word(18'h00022, 1'b1);
        check("fill_nfull",   {31'd0, new_nfull}, 32'd0);
        check("fill_wdata",   {14'd0, old_wdata}, 32'h11);
        check("fill_old_wen", {31'd0, old_wen},   32'd0);
        check("fill_dbg",     dbg,                32'h20);

        // Overflow: third write is dropped and the flag sticks
        write_word(18'h00033, 1'b0);
        check("ovf_set", {31'd0, new_woverflow}, 32'd1);
        check("ovf_dbg", dbg,                    32'h28);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i % 10 == 9) begin
                check("ovf_hold",   {31'd0, new_woverflow}, 32'd1);
                check("hold_wdata", {14'd0, old_wdata},     32'h11);
                check("hold_wen",   {31'd0, old_wen},       32'd0);
            end
        end

        // Drain: 0x11 then 0x22 on consecutive cycles
        old_nfull = 1'b1;
        #1;
        check("drain0_wen",  {31'd0, old_wen},   32'd1);
        check("drain0_data", {14'd0, old_wdata}, 32'h11);
        tick();
        check("drain1_wen",  {31'd0, old_wen},   32'd1);
        check("drain1_data", {14'd0, old_wdata}, 32'h22);
        tick();
        check("drain_done",  {31'd0, old_wen},   32'd0);
        check("drain_nfull", {31'd0, new_nfull}, 32'd1);

        // Simultaneous push and pop in state ONE
        write_word(18'h00055, 1'b1);
        check("one_data", {14'd0, old_wdata}, 32'h55);
        write_word(18'h00044, 1'b1);
        check("pp_occ",  {30'd0, dbg[5:4]},  32'd1);
        check("pp_data", {14'd0, old_wdata}, 32'h44);
        check("pp_wen",  {31'd0, old_wen},   32'd1);
        tick();
        check("pp_empty",     {30'd0, dbg[5:4]},      32'd0);
        check("ovf_persists", {31'd0, new_woverflow}, 32'd1);
`ifndef FIFO_WRIF_STAT_EN
        check("dbg_upper_zero", {8'd0, dbg[31:8]}, 32'd0);
`endif

        // Reset with two words stored: they must never be written
        old_nfull = 1'b0;
        write_word(18'h00066, 1'b1);
        write_word(18'h00077, 1'b1);
        check("pre_rst_occ", {30'd0, dbg[5:4]}, 32'd2);
        rst       = 1'b1;
        old_nfull = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        check("mid_rst_wen",   {31'd0, old_wen},       32'd0);
        check("mid_rst_nfull", {31'd0, new_nfull},     32'd0);
        check("mid_rst_ovf",   {31'd0, new_woverflow}, 32'd0);
        check("mid_rst_dbg",   dbg,                    32'h4);
        tick();
        check("post_rst_nfull", {31'd0, new_nfull}, 32'd1);
        check("post_rst_wen",   {31'd0, old_wen},   32'd0);
        tick();
        check("post_rst_idle",  {31'd0, old_wen},   32'd0);

`ifdef FIFO_WRIF_STAT_EN
        // 70000 pops: streaming push+pop, then one idle cycle for the last pop
        for (int i = 0; i < 70000; i++) begin
            write_word(DWID'(i), 1'b1);
        end
        tick();
        check("stat_pops", {16'd0, dbg[31:16]}, 32'd4464);
        check("stat_drops0", {24'd0, dbg[15:8]}, 32'd0);
        // 300 dropped writes, counter saturates at 255
        old_nfull = 1'b0;
        write_word(18'h00100, 1'b1);
        write_word(18'h00101, 1'b1);
        for (int i = 0; i < 300; i++) begin
            write_word(18'h00200, 1'b0);
            if (i == 9) check("stat_drops10", {24'd0, dbg[15:8]}, 32'd10);
        end
        check("stat_drops_sat", {24'd0, dbg[15:8]}, 32'd255);
        check("stat_pops_hold", {16'd0, dbg[31:16]}, 32'd4464);
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fifo_wrif_sk
